// File: rtl/s2_arb_pkg.sv
// Shared types and helpers for the S2 share arbiter.
package s2_arb_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // S2 decodes sel1 = A1|B1 and sel0 = A0&B0. Tying B1 low and B0 high
  // makes A1/A0 pass the select bits straight through.
  function automatic logic [3:0] sel_to_ab(input logic [1:0] sel);
    return {sel[1], 1'b0, sel[0], 1'b1};
  endfunction

  // Next round-robin start position after serving a requester.
  function automatic logic [1:0] next_ptr(input logic [1:0] served);
    return served + 2'd1;
  endfunction

endpackage

// File: rtl/s2_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping 3 -> 0.
module rr_pick
  import s2_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            found,
  output logic [1:0]      idx
);

  logic [1:0] cand;

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/s2_share_arbiter.sv
// Round-robin arbiter sharing one registered S2 select cell among four
// requesters. Grants in IDLE, lets S2 capture in SEL, presents the word
// downstream in HOLD until the valid/ready handshake.
module s2_share_arbiter
  import s2_arb_pkg::*;
#(
  parameter int SIZE = 5
) (
  input  logic            clk,
  input  logic            CLR,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic            A1,
  output logic            B1,
  output logic            A0,
  output logic            B0,
  input  logic [SIZE-1:0] s2_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output logic [1:0]      out_id,
  output logic            busy
);

  state_t     state;
  state_t     state_next;
  logic [1:0] ptr;
  logic [1:0] gnt_id;
  logic       found;
  logic [1:0] pick;
  logic       handshake;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  assign handshake = (state == HOLD) && out_ready;

  // State register; CLR aborts any transfer immediately.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = SEL;
      SEL:     state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant latch in IDLE and round-robin pointer advance on handshake.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      gnt_id <= 2'd0;
      ptr    <= 2'd0;
    end else begin
      if ((state == IDLE) && found) gnt_id <= pick;
      if (handshake)                ptr    <= next_ptr(gnt_id);
    end
  end

  // Outputs. Select lines follow gnt_id, which only changes in IDLE, so
  // they are frozen through SEL and HOLD and S2 cannot glitch out_data.
  always_comb begin
    {A1, B1, A0, B0} = sel_to_ab(gnt_id);
    out_valid        = (state == HOLD);
    busy             = (state != IDLE);
    out_data         = s2_out;
    out_id           = gnt_id;
    ack              = '0;
    if (handshake) ack[gnt_id] = 1'b1;
  end

  // A granted requester must hold its request until it is acknowledged.
  always_ff @(posedge clk) begin
    if (!CLR && (state != IDLE)) begin
      req_held_until_ack: assert (req[gnt_id]);
    end
  end

endmodule

// File: tb/tb_s2_share_arbiter.sv
// Bench for s2_share_arbiter with a behavioural S2 select cell.
module tb_s2_share_arbiter;

  logic       clk = 1'b0;
  logic       CLR;
  logic [3:0] req;
  logic [3:0] ack;
  logic       A1, B1, A0, B0;
  logic [4:0] s2_out;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic [1:0] out_id;
  logic       busy;
  logic [4:0] d [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] id;
    logic [4:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] req;
    logic [4:0] data;
    logic [1:0] exp_id;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  // Behavioural S2: registered 4-input select, async clear.
  logic [1:0] s2_sel;
  logic [4:0] s2_q;
  assign s2_sel = {A1 | B1, A0 & B0};
  assign s2_out = s2_q;
  always @(posedge clk or posedge CLR) begin
    if (CLR) s2_q <= 5'd0;
    else     s2_q <= d[s2_sel];
  end

  s2_share_arbiter #(.SIZE(5)) dut (
    .clk       (clk),
    .CLR       (CLR),
    .req       (req),
    .ack       (ack),
    .A1        (A1),
    .B1        (B1),
    .A0        (A0),
    .B0        (B0),
    .s2_out    (s2_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int sel_now();
    return int'(s2_sel);
  endfunction

  // Scoreboard: compare every handshake against the queued expectation;
  // ack must be silent outside handshakes.
  always @(negedge clk) begin
    if (!CLR) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_out_id", out_id, e.id);
          chk("sb_out_data", out_data, e.data);
          chk("sb_ack", ack, 4'b0001 << e.id);
        end
      end else begin
        chk("ack_idle", ack, 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ab"}, {A1, B1, A0, B0}, 4'b0001);
    chk({tag, "_data"}, out_data, 0);
  endtask

  task automatic push(input logic [1:0] id, input logic [4:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    sb.push_back(e);
  endtask

  // Run until n handshakes have been seen or the budget expires.
  task automatic run_hs(input string name, input int n, input int budget);
    int seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      cyc();
      if (out_valid && out_ready) seen++;
    end
    chk(name, seen, n);
  endtask

  initial begin
    vecs[0] = '{4'b0001, 5'h00, 2'd0};
    vecs[1] = '{4'b0010, 5'h1F, 2'd1};
    vecs[2] = '{4'b0100, 5'h15, 2'd2};
    vecs[3] = '{4'b0101, 5'h0A, 2'd0};
    vecs[4] = '{4'b1001, 5'h13, 2'd3};
    vecs[5] = '{4'b0110, 5'h06, 2'd1};
    vecs[6] = '{4'b1011, 5'h1E, 2'd3};

    CLR = 1'b1;
    req = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 5'd0;
    #1;
    check_reset_outputs("reset");
    cyc();
    cyc();
    CLR = 1'b0;

    // Single-request vectors, including ptr-dependent multi-request picks.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++)
        d[i] = (i == vecs[v].exp_id) ? vecs[v].data : (vecs[v].data ^ 5'h1F);
      req = vecs[v].req;
      out_ready = 1'b1;
      push(vecs[v].exp_id, vecs[v].data);
      #1;
      chk("vec_idle_valid", out_valid, 0);
      cyc();
      chk("vec_sel_busy", busy, 1);
      chk("vec_sel_lines", sel_now(), vecs[v].exp_id);
      chk("vec_sel_b1b0", {B1, B0}, 2'b01);
      chk("vec_sel_valid", out_valid, 0);
      cyc();
      chk("vec_hold_valid", out_valid, 1);
      cyc();
      chk("vec_back_idle", busy, 0);
    end
    req = 4'b0000;
    cyc();

    // Round robin with all requesters held.
    CLR = 1'b1;
    #1;
    check_reset_outputs("rr_reset");
    cyc();
    CLR = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = 5'(i + 1);
    req = 4'b1111;
    out_ready = 1'b1;
    push(2'd0, 5'd1); push(2'd1, 5'd2); push(2'd2, 5'd3);
    push(2'd3, 5'd4); push(2'd0, 5'd1);
    begin
      int n = 0;
      int last = 0;
      for (int c = 1; c <= 30 && n < 5; c++) begin
        cyc();
        if (out_valid && out_ready) begin
          if (n == 0) chk("rr_first_latency", c, 2);
          else        chk("rr_spacing", c - last, 3);
          last = c;
          n++;
        end
      end
      chk("rr_count", n, 5);
    end
    cyc();
    req = 4'b0000;
    cyc();

    // Back-pressure: HOLD frozen while out_ready is low.
    d[0] = 5'h03; d[1] = 5'h11; d[2] = 5'h0C; d[3] = 5'h1B;
    req = 4'b0100;
    out_ready = 1'b0;
    push(2'd2, 5'h0C);
    cyc();
    chk("bp_sel_ab", {A1, B1, A0, B0}, 4'b1001);
    cyc();
    chk("bp_hold_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      d[0] = 5'(k);
      cyc();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 5'h0C);
      chk("bp_id", out_id, 2);
      chk("bp_ab", {A1, B1, A0, B0}, 4'b1001);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ack_on_ready", ack, 4'b0100);
    cyc();
    req = 4'b0000;
    chk("bp_back_idle", busy, 0);

    // Wrap and fairness: ptr is 3 now, 3 must beat 0, then 0 follows.
    d[0] = 5'h07; d[1] = 5'h1F; d[2] = 5'h1F; d[3] = 5'h18;
    req = 4'b1001;
    push(2'd3, 5'h18);
    push(2'd0, 5'h07);
    run_hs("wrap_handshakes", 2, 12);
    cyc();
    req = 4'b0000;
    cyc();

    // CLR in HOLD aborts; ptr restarts at 0 so requester 0 goes first.
    d[0] = 5'h05; d[1] = 5'h11; d[2] = 5'h00; d[3] = 5'h00;
    req = 4'b0010;
    out_ready = 1'b0;
    cyc();
    cyc();
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_pre_data", out_data, 5'h11);
    out_ready = 1'b1;
    CLR = 1'b1;
    #1;
    check_reset_outputs("clr_mid");
    cyc();
    chk("clr_held_busy", busy, 0);
    CLR = 1'b0;
    req = 4'b0011;
    push(2'd0, 5'h05);
    push(2'd1, 5'h11);
    run_hs("clr_reserve_handshakes", 2, 12);
    cyc();
    req = 4'b0000;
    cyc();
    cyc();

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=%0d", checks, 0);
    $fatal(1, "timeout");
  end

endmodule
